// File: rtl/spi_slave_core.sv
// SPI slave byte engine with an FPro register interface (status/tx/clear/config).
// Optional overrun flag is built only when SPI_SLV_OVERRUN_EN is defined.
module spi_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_start;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    logic       r_cpol;
    logic       r_cpha;
    logic       r_cpol_act;
    logic       r_cpha_act;
    logic [7:0] r_tx_buf;
    logic       r_tx_empty;
    logic [7:0] r_shift_tx;
    logic [7:0] r_shift_rx;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;

    logic       w_sclk;
    logic       w_mosi;
    logic       w_ss;
    logic       w_ss_fall;
    logic       w_ss_rise;
    logic       w_lead;
    logic       w_trail;
    logic       w_in_byte;
    logic       w_sample;
    logic       w_shift;
    logic       w_done;
    logic       w_load;
    logic [7:0] w_rx_byte;
    logic       w_wr_tx;
    logic       w_wr_clr;
    logic       w_wr_cfg;
    logic       w_overrun;
    logic       w_ss_active;
    logic       w_unused;

    assign w_unused = &{1'b0, read, addr[4:2], wr_data[31:8]};

    // The ss_n chain resets low so a select still held across reset is not
    // mistaken for a fresh falling edge once reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss      = r_ss_sync[SYNC_STAGES-1];
    assign w_ss_fall = r_ss_prev & ~w_ss;
    assign w_ss_rise = ~r_ss_prev & w_ss;

    assign w_lead  = (r_sclk_prev == r_cpol_act) && (w_sclk != r_cpol_act);
    assign w_trail = (r_sclk_prev != r_cpol_act) && (w_sclk == r_cpol_act);

    // The first shift edge of each byte is skipped: the freshly loaded MSB
    // must stay on MISO until the master has sampled it.
    assign w_in_byte = (r_state == ACTIVE) && !w_ss_rise;
    assign w_sample  = w_in_byte && (r_cpha_act ? w_trail : w_lead);
    assign w_shift   = w_in_byte && (r_cpha_act ? w_lead : w_trail) && (r_bit_cnt != 3'd0);
    assign w_done    = w_sample && (r_bit_cnt == 3'd7);
    assign w_rx_byte = {r_shift_rx[6:0], w_mosi};
    assign w_load    = w_start || w_done;

    assign w_wr_tx  = cs && write && (addr[1:0] == 2'd1);
    assign w_wr_clr = cs && write && (addr[1:0] == 2'd2);
    assign w_wr_cfg = cs && write && (addr[1:0] == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Statement order encodes priority: byte completion beats a CPU clear,
    // and a CPU tx write beats the tx_empty set done by a shift_tx load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cpol_act <= 1'b0;
            r_cpha_act <= 1'b0;
            r_tx_buf   <= 8'h00;
            r_tx_empty <= 1'b1;
            r_shift_tx <= 8'h00;
            r_shift_rx <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_wr_cfg) begin
                r_cpol <= wr_data[0];
                r_cpha <= wr_data[1];
            end
            if (w_start) begin
                r_cpol_act <= r_cpol;
                r_cpha_act <= r_cpha;
            end

            if (w_start || ((r_state == ACTIVE) && w_ss_rise)) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_sample) begin
                r_shift_rx <= w_rx_byte;
            end

            if (w_wr_clr) begin
                r_rx_valid <= 1'b0;
            end
            if (w_done) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end

            if (w_load) begin
                r_shift_tx <= r_tx_empty ? 8'hFF : r_tx_buf;
                r_tx_empty <= 1'b1;
            end else if (w_shift) begin
                r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end
            if (w_wr_tx) begin
                r_tx_buf   <= wr_data[7:0];
                r_tx_empty <= 1'b0;
            end
        end
    end

`ifdef SPI_SLV_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_done && r_rx_valid) begin
            r_overrun <= 1'b1;
        end else if (w_wr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign w_overrun = r_overrun;
`else
    assign w_overrun = 1'b0;
`endif

    assign w_ss_active = (r_state == ACTIVE);
    assign spi_miso    = w_ss_active ? r_shift_tx[7] : 1'b0;
    assign spi_miso_oe = w_ss_active;
    assign rd_data     = {20'd0, w_overrun, w_ss_active, r_tx_empty, r_rx_valid, r_rx_data};

endmodule
